// File: rtl/mmio_uart_tx.sv
// Memory-mapped UART transmitter: byte FIFO plus 8N1 (or 8E1) serializer.
// Optional even parity bit is enabled with `define UART_TX_PARITY_EN.
//
// Ports:
//   clk            - system clock, rising edge
//   reset          - synchronous active-high reset
//   mem_address_in - CPU data address
//   mem_wdata_in   - CPU write data
//   mem_wenable_in - CPU write strobe (one cycle per write)
//   mem_rdata_out  - combinational read data (0 when not selected)
//   sel_out        - address falls inside the 16-byte register window
//   tx             - serial output, idle high
//
// Registers (offset = addr[3:2]):
//   0x0 DATA   W: push byte     R: 0
//   0x4 STATUS R: {parity_en, count[3:0], overflow, empty, full, busy}
//              W: clear overflow
//   0x8 BAUD   R/W: clocks per bit in [15:0], 0 is stored as 1
//   0xC reserved
module mmio_uart_tx #(
    parameter logic [31:0] BASE_ADDR   = 32'h80000010,
    parameter int          DEFAULT_DIV = 217,
    parameter int          FIFO_AW     = 3
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] mem_address_in,
    input  logic [31:0] mem_wdata_in,
    input  logic        mem_wenable_in,
    output logic [31:0] mem_rdata_out,
    output logic        sel_out,
    output logic        tx
);

    localparam int DEPTH = 2 ** FIFO_AW;
    localparam logic [FIFO_AW:0] FULL_CNT = {1'b1, {FIFO_AW{1'b0}}};
    localparam logic [15:0] DIV_RST = 16'(DEFAULT_DIV);

`ifdef UART_TX_PARITY_EN
    localparam logic PARITY_FLAG = 1'b1;
`else
    localparam logic PARITY_FLAG = 1'b0;
`endif

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    // ------------------------------------------------------------
    // Bus decode
    // ------------------------------------------------------------
    logic [1:0] reg_sel;
    logic       wr;
    logic       wr_data;
    logic       wr_status;
    logic       wr_baud;

    assign sel_out   = (mem_address_in[31:4] == BASE_ADDR[31:4]);
    assign reg_sel   = mem_address_in[3:2];
    assign wr        = sel_out & mem_wenable_in;
    assign wr_data   = wr & (reg_sel == 2'd0);
    assign wr_status = wr & (reg_sel == 2'd1);
    assign wr_baud   = wr & (reg_sel == 2'd2);

    logic unused_bits;
    assign unused_bits = ^{mem_wdata_in[31:16], mem_address_in[1:0]};

    // ------------------------------------------------------------
    // BAUD register
    // ------------------------------------------------------------
    logic [15:0] baud_reg;

    always_ff @(posedge clk) begin
        if (reset) begin
            baud_reg <= DIV_RST;
        end else if (wr_baud) begin
            baud_reg <= (mem_wdata_in[15:0] == 16'd0) ? 16'd1
                                                      : mem_wdata_in[15:0];
        end
    end

    // ------------------------------------------------------------
    // FIFO
    // ------------------------------------------------------------
    logic [7:0]         fifo_mem [DEPTH];
    logic [FIFO_AW-1:0] wr_ptr;
    logic [FIFO_AW-1:0] rd_ptr;
    logic [FIFO_AW:0]   count;
    logic               fifo_full;
    logic               fifo_empty;
    logic               overflow;
    logic               push;
    logic               pop;
    logic [7:0]         fifo_head;

    assign fifo_full  = (count == FULL_CNT);
    assign fifo_empty = (count == '0);
    // A full FIFO drops the byte even if a pop happens on the same edge.
    assign push       = wr_data & ~fifo_full;
    assign fifo_head  = fifo_mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr] <= mem_wdata_in[7:0];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (push && !pop) begin
                count <= count + 1'b1;
            end else if (!push && pop) begin
                count <= count - 1'b1;
            end
            if (wr_data && fifo_full) begin
                overflow <= 1'b1;
            end else if (wr_status) begin
                overflow <= 1'b0;
            end
        end
    end

    // ------------------------------------------------------------
    // Serializer FSM
    // ------------------------------------------------------------
    state_t      state, state_n;
    logic [15:0] cnt, cnt_n;
    logic [15:0] cur_div, cur_div_n;
    logic [2:0]  bit_idx, bit_idx_n;
    logic [7:0]  shreg, shreg_n;
    logic        par_q, par_n;
    logic        tx_q, tx_n;
    logic        bit_end;
    logic        start_frame;
    logic        busy;

    // cur_div is latched at every bit start, so a BAUD write only
    // affects bits that begin after it.
    assign bit_end = ((cnt + 16'd1) == cur_div);
    assign busy    = (state != S_IDLE);
    assign tx      = tx_q;

    // Frames chain straight from the end of STOP into the next START
    // so back-to-back bytes have no idle gap.
    assign start_frame = !fifo_empty &&
                         ((state == S_IDLE) ||
                          (state == S_STOP && bit_end));

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= S_IDLE;
            cnt     <= '0;
            cur_div <= DIV_RST;
            bit_idx <= '0;
            shreg   <= '0;
            par_q   <= 1'b0;
            tx_q    <= 1'b1;
        end else begin
            state   <= state_n;
            cnt     <= cnt_n;
            cur_div <= cur_div_n;
            bit_idx <= bit_idx_n;
            shreg   <= shreg_n;
            par_q   <= par_n;
            tx_q    <= tx_n;
        end
    end

    always_comb begin
        state_n   = state;
        cnt_n     = cnt + 16'd1;
        cur_div_n = cur_div;
        bit_idx_n = bit_idx;
        shreg_n   = shreg;
        par_n     = par_q;
        tx_n      = tx_q;
        pop       = 1'b0;

        unique case (state)
            S_IDLE: begin
                cnt_n = '0;
                tx_n  = 1'b1;
            end
            S_START: begin
                if (bit_end) begin
                    tx_n      = shreg[0];
                    bit_idx_n = '0;
                    state_n   = S_DATA;
                end
            end
            S_DATA: begin
                if (bit_end) begin
                    if (bit_idx == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                        tx_n    = par_q;
                        state_n = S_PARITY;
`else
                        tx_n    = 1'b1;
                        state_n = S_STOP;
`endif
                    end else begin
                        tx_n      = shreg[1];
                        shreg_n   = {1'b0, shreg[7:1]};
                        bit_idx_n = bit_idx + 3'd1;
                    end
                end
            end
            S_PARITY: begin
                if (bit_end) begin
                    tx_n    = 1'b1;
                    state_n = S_STOP;
                end
            end
            S_STOP: begin
                if (bit_end) begin
                    tx_n    = 1'b1;
                    state_n = S_IDLE;
                end
            end
            default: begin
                tx_n    = 1'b1;
                state_n = S_IDLE;
            end
        endcase

        if (state != S_IDLE && bit_end) begin
            cnt_n     = '0;
            cur_div_n = baud_reg;
        end

        if (start_frame) begin
            pop       = 1'b1;
            shreg_n   = fifo_head;
            par_n     = ^fifo_head;
            tx_n      = 1'b0;
            cnt_n     = '0;
            cur_div_n = baud_reg;
            state_n   = S_START;
        end
    end

    // ------------------------------------------------------------
    // Read mux
    // ------------------------------------------------------------
    logic [31:0] status_word;

    assign status_word = {23'd0, PARITY_FLAG, 4'(count),
                          overflow, fifo_empty, fifo_full, busy};

    always_comb begin
        mem_rdata_out = '0;
        if (sel_out) begin
            unique case (reg_sel)
                2'd1:    mem_rdata_out = status_word;
                2'd2:    mem_rdata_out = {16'd0, baud_reg};
                default: mem_rdata_out = '0;
            endcase
        end
    end

endmodule
